coin_input_conditioner: RTL and testbench
=========================================

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 SHALL have parameter DB_COUNT, default 500000, meaning synced-input cycles a new level must persist before it is accepted (5 ms at 100 MHz); legal range 2..2^CNT_W.
REQ-002 SHALL have parameter CNT_W, default 20, meaning debounce counter width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in2, in1, in0  input  1 each  raw asynchronous coin buttons, worth 1, 2 and 3 credits respectively.
REQ-006 SHALL have port coin_ready  input  1  consumer accepts the current coin.
REQ-007 SHALL have port coin_valid  output  1  a coin is offered.
REQ-008 SHALL have port coin_value  output  2  credit of offered coin (1, 2 or 3); 0 when coin_valid low.
REQ-009 SHALL have port held  output  3  debounced levels {in2, in1, in0}.
REQ-010 SHALL have port dropped  output  1  sticky flag: at least one press was lost.

Function
REQ-011 Each input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per input: stable-level register; CNT_W-bit counter cleared whenever synced level equals stable level, incremented otherwise.
REQ-013 When synced != stable and counter == DB_COUNT-1, stable SHALL take the synced level and counter SHALL clear on that edge.
REQ-014 Synced mismatch lasting fewer than DB_COUNT consecutive cycles SHALL not change stable level (glitch rejection, both polarities).
REQ-015 A stable 0->1 transition SHALL set that button's pending bit on the same edge; 1->0 transitions generate no event.
REQ-016 coin_valid SHALL be registered-state-derived: high iff any pending bit set.
REQ-017 Offered coin SHALL be chosen by fixed priority in0 (value 3) > in1 (value 2) > in2 (value 1); coin_value combinational from pending bits.
REQ-018 On an edge with coin_valid && coin_ready, the offered pending bit SHALL clear; other pending bits unaffected; at most one coin accepted per cycle.
REQ-019 coin_valid/coin_value SHALL hold unchanged while coin_ready low, except that a higher-priority press arriving may change the offered coin.
REQ-020 If a press sets a pending bit on the same edge that bit is accepted, the bit SHALL remain set (no loss, dropped unaffected).
REQ-021 If a press occurs while its pending bit is set and not being accepted, the press SHALL be discarded and dropped SHALL set.
REQ-022 Latency: raw input held high from edge k SHALL give coin_valid high after edge k+DB_COUNT+2.
REQ-023 held SHALL equal the stable-level registers directly.

Reset
REQ-024 While reset is high at a clock edge: synchronizers, stable levels, counters, pending bits and dropped SHALL clear; coin_valid=0, coin_value=0, held=0 after that edge.
REQ-025 Reset SHALL override any simultaneous press, acceptance or debounce completion.
REQ-026 Button held through reset release SHALL be treated as a new press and yield one coin per REQ-022, counted from the first edge after reset deasserts.

Verification (DB_COUNT=4)
REQ-027 in2 raised at edge 0, held -> coin_valid=1, coin_value=1 after edge 6; coin_ready=1 -> coin_valid=0 after edge 7; held=3'b100.
REQ-028 in1 pulsed high for 3 synced cycles, then low -> no coin_valid, held stays 0, dropped=0.
REQ-029 in0, in1, in2 raised same edge, coin_ready=1 -> coins 3, 2, 1 on three consecutive cycles; dropped=0.
REQ-030 coin_ready=0; in0 press, release, press again (each phase >=6 cycles) -> single coin value 3 offered, dropped=1; after coin_ready=1 one acceptance, coin_valid=0, dropped stays 1.
REQ-031 Pending coin value 2 with coin_valid high, reset asserted one edge -> coin_valid=0, coin_value=0, held=0, dropped=0 next cycle; in1 still high -> coin value 2 reappears 6 edges after reset release.
REQ-032 Bouncing in2 (toggle every 2 cycles for 20 cycles, then high) -> exactly one coin value 1.

Source files
------------

// File: rtl/coin_input_conditioner.sv
// Coin button conditioner: synchronizes and debounces three raw coin buttons,
// turns each debounced press into a pending coin, and offers pending coins one
// at a time over a valid/ready handshake (in0=3 > in1=2 > in2=1 credits).
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous active-high reset
//   in2/in1/in0 raw asynchronous buttons (1, 2, 3 credits)
//   coin_ready  consumer accepts the offered coin
//   coin_valid  a coin is offered (any pending bit set)
//   coin_value  credit of offered coin, 0 when none
//   held        debounced levels {in2, in1, in0}
//   dropped     sticky: a press arrived while its coin was still pending
module coin_input_conditioner #(
    parameter int unsigned DB_COUNT = 500000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in2,
    input  logic       in1,
    input  logic       in0,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [1:0] coin_value,
    output logic [2:0] held,
    output logic       dropped
);

    localparam int unsigned NB = 3;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    stable_nxt;
    logic [NB-1:0]    pending;
    logic [NB-1:0]    pending_nxt;
    logic [NB-1:0]    rise;
    logic [NB-1:0]    accept;
    logic             dropped_nxt;
    logic [CNT_W-1:0] cnt     [NB];
    logic [CNT_W-1:0] cnt_nxt [NB];

    assign raw = {in2, in1, in0};

    // Debounce: count consecutive mismatch cycles, accept new level on the last one
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < int'(NB); i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == DB_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Fixed-priority acceptance of the offered coin
    always_comb begin
        accept = '0;
        if (coin_ready) begin
            if (pending[0])      accept = 3'b001;
            else if (pending[1]) accept = 3'b010;
            else if (pending[2]) accept = 3'b100;
        end
    end

    // A new press wins over a same-edge acceptance; a press onto a held pending bit is lost
    always_comb begin
        rise        = stable_nxt & ~stable;
        pending_nxt = (pending & ~accept) | rise;
        dropped_nxt = dropped | (|(rise & pending & ~accept));
    end

    // Offered coin value straight from the pending register
    always_comb begin
        coin_value = 2'd0;
        if (pending[0])      coin_value = 2'd3;
        else if (pending[1]) coin_value = 2'd2;
        else if (pending[2]) coin_value = 2'd1;
    end

    assign coin_valid = |pending;
    assign held       = stable;

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            pending <= '0;
            dropped <= 1'b0;
            for (int i = 0; i < int'(NB); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            stable  <= stable_nxt;
            pending <= pending_nxt;
            dropped <= dropped_nxt;
            for (int i = 0; i < int'(NB); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner (DB_COUNT=4): stimulus pushes the
// expected coin values into a queue, a negedge monitor pops one per accepted coin.
module tb_coin_input_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic       in2, in1, in0;
    logic       coin_ready;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic [2:0] held;
    logic       dropped;

    int vectors    = 0;
    int miscompares = 0;
    int exp_q[$];
    int mon_exp;

    coin_input_conditioner #(.DB_COUNT(4), .CNT_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .in2        (in2),
        .in1        (in1),
        .in0        (in0),
        .coin_ready (coin_ready),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .held       (held),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then drive just after the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Scoreboard monitor: every handshake must match the next expected coin
    always @(negedge clock) begin
        if (!reset && coin_valid && coin_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_coin: got value %0d expected none", coin_value);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_coin_value", int'(coin_value), mon_exp);
            end
        end
    end

    initial begin
        reset = 1'b1; in2 = 1'b0; in1 = 1'b0; in0 = 1'b0; coin_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        sample();
        chk("rst_valid",   int'(coin_valid), 0);
        chk("rst_value",   int'(coin_value), 0);
        chk("rst_held",    int'(held),       0);
        chk("rst_dropped", int'(dropped),    0);

        // Single in2 press: coin after edge 6, accepted on edge 7
        tick(1); in2 = 1'b1;
        tick(5); sample();
        chk("t1_not_yet", int'(coin_valid), 0);
        tick(1);
        exp_q.push_back(1);
        coin_ready = 1'b1;
        sample();
        chk("t1_valid", int'(coin_valid), 1);
        chk("t1_value", int'(coin_value), 1);
        chk("t1_held",  int'(held),       4);
        tick(1); coin_ready = 1'b0;
        sample();
        chk("t1_cleared", int'(coin_valid), 0);
        tick(1); in2 = 1'b0;
        tick(8); sample();
        chk("t1_release_held",  int'(held),       0);
        chk("t1_release_valid", int'(coin_valid), 0);

        // Short in1 pulse is rejected
        tick(1); in1 = 1'b1;
        tick(3); in1 = 1'b0;
        tick(10); sample();
        chk("t2_valid",   int'(coin_valid), 0);
        chk("t2_held",    int'(held),       0);
        chk("t2_dropped", int'(dropped),    0);

        // Simultaneous presses drain in priority order
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1);
        coin_ready = 1'b1;
        tick(1); in0 = 1'b1; in1 = 1'b1; in2 = 1'b1;
        tick(6); sample();
        chk("t3_first", int'(coin_value), 3);
        tick(1); sample();
        chk("t3_second", int'(coin_value), 2);
        tick(1); sample();
        chk("t3_third", int'(coin_value), 1);
        tick(1); sample();
        chk("t3_empty",   int'(coin_valid), 0);
        chk("t3_dropped", int'(dropped),    0);
        coin_ready = 1'b0;
        in0 = 1'b0; in1 = 1'b0; in2 = 1'b0;
        tick(8);

        // Second in0 press while first is pending is dropped
        in0 = 1'b1; tick(8);
        in0 = 1'b0; tick(8);
        in0 = 1'b1; tick(8);
        sample();
        chk("t4_valid",   int'(coin_valid), 1);
        chk("t4_value",   int'(coin_value), 3);
        chk("t4_dropped", int'(dropped),    1);
        exp_q.push_back(3);
        tick(1); coin_ready = 1'b1;
        tick(1); coin_ready = 1'b0;
        sample();
        chk("t4_empty",        int'(coin_valid), 0);
        chk("t4_dropped_kept", int'(dropped),    1);
        tick(1); in0 = 1'b0;
        tick(8);

        // Reset while a coin is pending; held button yields a fresh coin
        in1 = 1'b1;
        tick(6); sample();
        chk("t5_pre_valid", int'(coin_valid), 1);
        chk("t5_pre_value", int'(coin_value), 2);
        tick(1); reset = 1'b1;
        tick(1); reset = 1'b0;
        sample();
        chk("t5_rst_valid",   int'(coin_valid), 0);
        chk("t5_rst_value",   int'(coin_value), 0);
        chk("t5_rst_held",    int'(held),       0);
        chk("t5_rst_dropped", int'(dropped),    0);
        tick(5); sample();
        chk("t5_not_yet", int'(coin_valid), 0);
        tick(1); sample();
        chk("t5_valid", int'(coin_valid), 1);
        chk("t5_value", int'(coin_value), 2);
        chk("t5_held",  int'(held),       2);
        exp_q.push_back(2);
        tick(1); coin_ready = 1'b1;
        tick(1); coin_ready = 1'b0;
        sample();
        chk("t5_empty", int'(coin_valid), 0);
        tick(1); in1 = 1'b0;
        tick(8);

        // Bouncing in2 settles into exactly one coin
        exp_q.push_back(1);
        coin_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in2 = (k % 2 == 0);
            tick(2);
        end
        in2 = 1'b1;
        tick(12); sample();
        chk("t6_valid", int'(coin_valid), 0);
        chk("t6_held",  int'(held),       4);
        coin_ready = 1'b0;
        tick(2);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
